// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte packer and the downstream byte-manipulation datapath:
// lane-order encodings and the byte-index to lane mapping.
package byte_word_packer_pkg;

    localparam int unsigned DEFAULT_WORD_BYTES = 4;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

    // Lane that holds byte number cnt of a word for the given order.
    function automatic int unsigned lane_of(
        input int unsigned cnt,
        input logic        order,
        input int unsigned nbytes = DEFAULT_WORD_BYTES
    );
        case (order)
            ORDER_MSB_FIRST: return nbytes - 1 - cnt;
            ORDER_LSB_FIRST: return cnt;
            default:         return cnt;
        endcase
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into WORD_BYTES-wide words with per-word lane order,
// early word close on in_last, and a single registered output stage.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_byte,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic [WORD_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic [CNT_W-1:0]        word_count
);

    localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned DW    = 8 * WORD_BYTES;

    logic [DW-1:0]         r_acc;
    logic [WORD_BYTES-1:0] r_acc_keep;
    logic [IDX_W-1:0]      r_cnt;
    logic                  r_word_mode;

    logic                  r_out_valid;
    logic [DW-1:0]         r_out_data;
    logic [WORD_BYTES-1:0] r_out_keep;
    logic                  r_out_last;
    logic [CNT_W-1:0]      r_word_count;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_order;
    logic                  w_complete;
    logic [IDX_W-1:0]      w_lane;
    logic [DW-1:0]         w_byte_word;
    logic [WORD_BYTES-1:0] w_lane_bit;

    assign w_in_ready = enable && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    // The first byte of a word picks the order; later bytes reuse the latched one.
    assign w_order    = (r_cnt == '0) ? mode : r_word_mode;
    assign w_lane     = IDX_W'(lane_of(32'(r_cnt), w_order, WORD_BYTES));
    assign w_complete = (r_cnt == IDX_W'(WORD_BYTES - 1)) || in_last;

    always_comb begin
        w_byte_word = '0;
        w_lane_bit  = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (w_lane == IDX_W'(i)) begin
                w_byte_word[8*i +: 8] = in_byte;
                w_lane_bit[i]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_acc_keep   <= '0;
            r_cnt        <= '0;
            r_word_mode  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (r_cnt == '0) begin
                    r_word_mode <= mode;
                end
                // A completing byte overrides the drain above so back-to-back words have no bubble.
                if (w_complete) begin
                    r_out_data   <= r_acc | w_byte_word;
                    r_out_keep   <= r_acc_keep | w_lane_bit;
                    r_out_last   <= in_last;
                    r_out_valid  <= 1'b1;
                    r_acc        <= '0;
                    r_acc_keep   <= '0;
                    r_cnt        <= '0;
                    r_word_count <= r_word_count + CNT_W'(1);
                end else begin
                    r_acc      <= r_acc | w_byte_word;
                    r_acc_keep <= r_acc_keep | w_lane_bit;
                    r_cnt      <= r_cnt + IDX_W'(1);
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_keep   = r_out_keep;
    assign out_last   = r_out_last;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: expected words are queued by the stimulus
// process and checked by a monitor on every output handshake.
module tb_byte_word_packer;
    import byte_word_packer_pkg::*;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          mode = ORDER_MSB_FIRST;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_byte = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_last;
    logic [CW-1:0] word_count;

    typedef struct {
        logic [31:0]   d;
        logic [3:0]    k;
        logic          l;
        logic [CW-1:0] c;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    byte_word_packer #(.WORD_BYTES(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                               input logic [CW-1:0] c);
        exp_t e;
        e.d = d; e.k = k; e.l = l; e.c = c;
        q.push_back(e);
    endtask

    // Present one byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] b, input logic l, input logic m);
        int n = 0;
        in_valid = 1'b1; in_byte = b; in_last = l; mode = m;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(n), 64'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_word: got data=%h keep=%b last=%b count=%0d, none expected",
                         out_data, out_keep, out_last, word_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_data !== e.d || out_keep !== e.k || out_last !== e.l || word_count !== e.c) begin
                    mismatched++;
                    $display("FAIL word: got data=%h keep=%b last=%b count=%0d expected data=%h keep=%b last=%b count=%0d",
                             out_data, out_keep, out_last, word_count, e.d, e.k, e.l, e.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_keep", 64'(out_keep), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_word_count", 64'(word_count), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // MSB-first full word, with one-cycle latency check
        expect_word(32'h11223344, 4'b1111, 1'b0, 3'd1);
        send(8'h11, 1'b0, ORDER_MSB_FIRST);
        send(8'h22, 1'b0, ORDER_MSB_FIRST);
        send(8'h33, 1'b0, ORDER_MSB_FIRST);
        send(8'h44, 1'b0, ORDER_MSB_FIRST);
        chk("latency_out_valid", 64'(out_valid), 64'(1));

        // LSB-first full word
        expect_word(32'h44332211, 4'b1111, 1'b0, 3'd2);
        send(8'h11, 1'b0, ORDER_LSB_FIRST);
        send(8'h22, 1'b0, ORDER_LSB_FIRST);
        send(8'h33, 1'b0, ORDER_LSB_FIRST);
        send(8'h44, 1'b0, ORDER_LSB_FIRST);

        // Mode change mid-word must be ignored
        expect_word(32'h44332211, 4'b1111, 1'b0, 3'd3);
        send(8'h11, 1'b0, ORDER_LSB_FIRST);
        send(8'h22, 1'b0, ORDER_LSB_FIRST);
        send(8'h33, 1'b0, ORDER_MSB_FIRST);
        send(8'h44, 1'b0, ORDER_MSB_FIRST);

        // Early close on in_last
        expect_word(32'hAABB0000, 4'b1100, 1'b1, 3'd4);
        send(8'hAA, 1'b0, ORDER_MSB_FIRST);
        send(8'hBB, 1'b1, ORDER_MSB_FIRST);

        // Back-pressure: two words queued behind a stalled consumer
        @(posedge clk); #1;
        out_ready = 1'b0;
        expect_word(32'h01020304, 4'b1111, 1'b0, 3'd5);
        expect_word(32'h05060708, 4'b1111, 1'b0, 3'd6);
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, ORDER_MSB_FIRST);
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_out_valid", 64'(out_valid), 64'(1));
                chk("bp_in_ready", 64'(in_ready), 64'(0));
                chk("bp_hold_data", 64'(out_data), 64'h01020304);
                repeat (3) @(negedge clk);
                chk("bp_hold_data_later", 64'(out_data), 64'h01020304);
                chk("bp_hold_count", 64'(word_count), 64'(5));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Enable low stalls input while a partial word is held
        expect_word(32'hA1A2A3A4, 4'b1111, 1'b0, 3'd7);
        send(8'hA1, 1'b0, ORDER_MSB_FIRST);
        send(8'hA2, 1'b0, ORDER_MSB_FIRST);
        enable = 1'b0;
        in_valid = 1'b1; in_byte = 8'hA3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_low_in_ready", 64'(in_ready), 64'(0));
        end
        chk("en_low_no_word", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        enable = 1'b1;
        send(8'hA3, 1'b0, ORDER_MSB_FIRST);
        send(8'hA4, 1'b0, ORDER_MSB_FIRST);

        // Full word with in_last on the final byte; word_count wraps to 0
        expect_word(32'hD4D3D2D1, 4'b1111, 1'b1, 3'd0);
        send(8'hD1, 1'b0, ORDER_LSB_FIRST);
        send(8'hD2, 1'b0, ORDER_LSB_FIRST);
        send(8'hD3, 1'b0, ORDER_LSB_FIRST);
        send(8'hD4, 1'b1, ORDER_LSB_FIRST);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-word discards the partial bytes
        send(8'hB1, 1'b0, ORDER_MSB_FIRST);
        send(8'hB2, 1'b0, ORDER_MSB_FIRST);
        send(8'hB3, 1'b0, ORDER_MSB_FIRST);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_word_count", 64'(word_count), 64'(0));
        expect_word(32'hC1C2C3C4, 4'b1111, 1'b0, 3'd1);
        send(8'hC1, 1'b0, ORDER_MSB_FIRST);
        send(8'hC2, 1'b0, ORDER_MSB_FIRST);
        send(8'hC3, 1'b0, ORDER_MSB_FIRST);
        send(8'hC4, 1'b0, ORDER_MSB_FIRST);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
